// File: rtl/init_ram_pkg.sv
// rtl/init_ram_pkg.sv - shared types, mode constants and preload pattern for init_ram_ctrl
package init_ram_pkg;

  typedef enum logic {IDLE, INIT} state_t;

  localparam int MODE_IDENTITY = 0;
  localparam int MODE_ZERO     = 1;

  // Returned wide; the caller narrows it to the data width.
  function automatic logic [63:0] init_pattern(input logic [31:0] cnt, input int mode);
    return (mode == MODE_ZERO) ? 64'd0 : {32'd0, cnt};
  endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// rtl/ram_sp_sync.sv - single-port RAM with one write port and a registered read port
module ram_sp_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // The array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (we) mem[address] <= d;
  end

  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (re) q <= mem[address];
  end

endmodule

// File: rtl/init_ram_ctrl.sv
// rtl/init_ram_ctrl.sv - working RAM with a hardware preload sequencer and busy flag
module init_ram_ctrl
  import init_ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int INIT_WORDS = 16,
  parameter int INIT_MODE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_start,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INIT_WORDS - 1);

  if (INIT_WORDS < 1 || INIT_WORDS > (1 << ADDR_W) ||
      (INIT_MODE != MODE_IDENTITY && INIT_MODE != MODE_ZERO)) begin : g_bad_params
    $error("init_ram_ctrl: illegal INIT_WORDS or INIT_MODE");
  end

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      q_valid <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      q_valid <= mem_re;
    end
  end

  // Priority in IDLE is init_start, then write, then read.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = address;
    mem_d      = d;
    case (state)
      IDLE: begin
        if (init_start) begin
          state_next = INIT;
          cnt_next   = '0;
        end else if (we) begin
          mem_we = 1'b1;
        end else if (re) begin
          mem_re = 1'b1;
        end
      end
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = cnt[ADDR_W-1:0];
        mem_d    = DATA_W'(init_pattern(32'(cnt), INIT_MODE));
        cnt_next = cnt + 1'b1;
        if (cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == INIT);

  ram_sp_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (mem_we),
    .re      (mem_re),
    .address (mem_addr),
    .d       (mem_d),
    .q       (q)
  );

endmodule

// File: tb/tb_init_ram_ctrl.sv
// tb/tb_init_ram_ctrl.sv - directed self-checking bench for init_ram_ctrl
module tb_init_ram_ctrl;

  logic       clock;
  logic       reset, init_start, we, re;
  logic [4:0] address;
  logic [7:0] d, q;
  logic       q_valid, busy;

  logic        reset2, init_start2, we2, re2;
  logic [3:0]  address2;
  logic [15:0] d2, q2;
  logic        q_valid2, busy2;

  int total = 0;
  int bad   = 0;
  int n;
  logic [7:0] exp5 [0:7];
  logic [4:0] adr5 [0:7];

  init_ram_ctrl dut (
    .clock(clock), .reset(reset), .init_start(init_start), .we(we), .re(re),
    .address(address), .d(d), .q(q), .q_valid(q_valid), .busy(busy)
  );

  init_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .INIT_WORDS(16), .INIT_MODE(1)) dut2 (
    .clock(clock), .reset(reset2), .init_start(init_start2), .we(we2), .re(re2),
    .address(address2), .d(d2), .q(q2), .q_valid(q_valid2), .busy(busy2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e, input string tag);
    re = 1'b1; address = a;
    tick();
    re = 1'b0;
    chk({tag, "_q"}, 32'(q), 32'(e));
    chk({tag, "_qv"}, 32'(q_valid), 32'd1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] v);
    we = 1'b1; address = a; d = v;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_start = 1'b0; we = 1'b0; re = 1'b0; address = '0; d = '0;
    reset2 = 1'b1; init_start2 = 1'b0; we2 = 1'b0; re2 = 1'b0; address2 = '0; d2 = '0;
    tick(); tick();
    reset = 1'b0; reset2 = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);

    // 1: default identity preload
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      tick();
    end
    chk("t1_busy_cycles", 32'(n), 16);
    for (int a = 0; a < 16; a++) rd(5'(a), 8'(a), "t1_rd");
    tick();
    chk("t1_qv_drop", 32'(q_valid), 0);

    // 2: write then read back
    we = 1'b1; address = 5'd20; d = 8'hA5;
    tick();
    we = 1'b0;
    chk("t2_wr_qv", 32'(q_valid), 0);
    rd(5'd20, 8'hA5, "t2_rd");
    tick();
    chk("t2_qv_pulse", 32'(q_valid), 0);
    chk("t2_q_hold", 32'(q), 32'h A5);

    // 3: simultaneous we and re, write wins
    we = 1'b1; re = 1'b1; address = 5'd3; d = 8'h77;
    tick();
    we = 1'b0; re = 1'b0;
    chk("t3_qv", 32'(q_valid), 0);
    chk("t3_q_unch", 32'(q), 32'hA5);
    rd(5'd3, 8'h77, "t3_rd");

    // 4: accesses ignored while busy
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    we = 1'b1; re = 1'b1; address = 5'd2; d = 8'hFF;
    tick();
    chk("t4_busy", 32'(busy), 1);
    chk("t4_qv", 32'(q_valid), 0);
    chk("t4_q_hold", 32'(q), 32'h77);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      tick();
    end
    we = 1'b0; re = 1'b0;
    chk("t4_busy_cycles", 32'(n), 16);
    rd(5'd2, 8'h02, "t4_rd2");
    rd(5'd3, 8'h03, "t4_rd3");
    rd(5'd20, 8'hA5, "t4_rd20");

    // 5: reset aborts preload after the 5th word
    for (int a = 0; a < 7; a++) wr(5'(a), 8'hEE);
    wr(5'd10, 8'h55);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (4) tick();
    chk("t5_busy_before", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy_after", 32'(busy), 0);
    chk("t5_q_rst", 32'(q), 0);
    chk("t5_qv_rst", 32'(q_valid), 0);
    adr5 = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd10};
    exp5 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEE, 8'hEE, 8'h55};
    for (int i = 0; i < 8; i++) rd(adr5[i], exp5[i], "t5_rd");

    // 6: zero-fill variant, 16-bit data
    init_start2 = 1'b1;
    tick();
    init_start2 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy2) break;
      n++;
      tick();
    end
    chk("t6_busy_cycles", 32'(n), 16);
    for (int a = 0; a < 16; a++) begin
      re2 = 1'b1; address2 = 4'(a);
      tick();
      re2 = 1'b0;
      chk("t6_rd_q", 32'(q2), 0);
      chk("t6_rd_qv", 32'(q_valid2), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
